// File: rtl/minialu_mul_datapath_pkg.sv
// Shared constants and types for the MiniAlu execution-side datapath slice.
//   - Default widths for the data RAM and the nibble multiplier.
//   - Operand-select encoding (RL/RH) used by the enclosing ALU result mux.
//     This slice does not consume it; it lives here so every block of the
//     ALU agrees on one encoding.
package minialu_mul_datapath_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int MUL_WIDTH_DEF  = 4;

  // Operand select for the ALU result mux: low or high register operand.
  typedef enum logic {
    OPSEL_RL = 1'b0,
    OPSEL_RH = 1'b1
  } opsel_e;

  localparam logic RL = 1'b0;
  localparam logic RH = 1'b1;

  // Width of the full product for a given operand width.
  function automatic int prod_width(input int mul_width);
    return 2 * mul_width;
  endfunction

endpackage

// File: rtl/minialu_mul_datapath_if.sv
// Bus between instruction decode (master) and the multiply datapath (slave).
//   write_enable/write_address/data_in : RAM write port
//   read_address0/read_address1        : RAM read port addresses
//   mul_enable                          : product register load enable
//   data_out0/data_out1                 : combinational RAM read data
//   mul_comb                            : unregistered product
//   product                             : registered product
interface minialu_mul_datapath_if
  import minialu_mul_datapath_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int MUL_WIDTH  = MUL_WIDTH_DEF
);

  logic                   write_enable;
  logic [ADDR_WIDTH-1:0]  write_address;
  logic [DATA_WIDTH-1:0]  data_in;
  logic [ADDR_WIDTH-1:0]  read_address0;
  logic [ADDR_WIDTH-1:0]  read_address1;
  logic                   mul_enable;
  logic [DATA_WIDTH-1:0]  data_out0;
  logic [DATA_WIDTH-1:0]  data_out1;
  logic [2*MUL_WIDTH-1:0] mul_comb;
  logic [2*MUL_WIDTH-1:0] product;

  modport master (
    output write_enable, write_address, data_in,
    output read_address0, read_address1, mul_enable,
    input  data_out0, data_out1, mul_comb, product
  );

  modport slave (
    input  write_enable, write_address, data_in,
    input  read_address0, read_address1, mul_enable,
    output data_out0, data_out1, mul_comb, product
  );

endinterface

// File: rtl/minialu_mul_datapath_array_mul.sv
// Combinational unsigned shift-add array multiplier.
//   a, b : MUL_WIDTH-bit unsigned operands
//   p    : exact 2*MUL_WIDTH-bit product
// Row i is a AND b[i], shifted left by i; rows are accumulated one after
// another so each stage is a single adder fed by the previous stage.
module array_mul_unsigned #(
  parameter int MUL_WIDTH = 4
) (
  input  logic [MUL_WIDTH-1:0]   a,
  input  logic [MUL_WIDTH-1:0]   b,
  output logic [2*MUL_WIDTH-1:0] p
);

  localparam int PW = 2 * MUL_WIDTH;

  logic [PW-1:0] row     [MUL_WIDTH];
  logic [PW-1:0] partial [MUL_WIDTH];

  for (genvar gi = 0; gi < MUL_WIDTH; gi++) begin : g_rows
    assign row[gi] = {{MUL_WIDTH{1'b0}}, (a & {MUL_WIDTH{b[gi]}})} << gi;
    if (gi == 0) begin : g_first
      assign partial[gi] = row[gi];
    end else begin : g_chain
      assign partial[gi] = partial[gi-1] + row[gi];
    end
  end

  assign p = partial[MUL_WIDTH-1];

endmodule

// File: rtl/minialu_mul_datapath_dff_en_arst.sv
// Generic enabled register with asynchronous active-low clear.
//   clk   : clock, rising edge
//   rst_n : asynchronous clear to zero, active low
//   en    : load enable; q holds when low
//   d/q   : WIDTH-bit data in / registered out
module dff_en_arst #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/minialu_mul_datapath.sv
// MiniAlu multiply datapath slice.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (clears the product register only)
//   bus   : slave side of minialu_mul_datapath_if
//           - 2^ADDR_WIDTH x DATA_WIDTH RAM, one sync write, two async reads
//           - nibble multiply of the two read words (mul_comb)
//           - enabled product register (product)
module minialu_mul_datapath
  import minialu_mul_datapath_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int MUL_WIDTH  = MUL_WIDTH_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  minialu_mul_datapath_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // RAM contents are deliberately outside reset; software initialises them.
  // Reads are asynchronous, so this maps to distributed RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (bus.write_enable) begin
      mem[bus.write_address] <= bus.data_in;
    end
  end

  // No write bypass: a read of the word being written shows the old value
  // until the edge, which also makes a same-cycle multiply use old operands.
  assign bus.data_out0 = mem[bus.read_address0];
  assign bus.data_out1 = mem[bus.read_address1];

  logic [2*MUL_WIDTH-1:0] mul_comb;

  array_mul_unsigned #(
    .MUL_WIDTH (MUL_WIDTH)
  ) u_mul (
    .a (bus.data_out1[MUL_WIDTH-1:0]),
    .b (bus.data_out0[MUL_WIDTH-1:0]),
    .p (mul_comb)
  );

  assign bus.mul_comb = mul_comb;

  dff_en_arst #(
    .WIDTH (2*MUL_WIDTH)
  ) u_product (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.mul_enable),
    .d     (mul_comb),
    .q     (bus.product)
  );

endmodule

// File: tb/tb_minialu_mul_datapath.sv
// Directed testbench for minialu_mul_datapath.
module tb_minialu_mul_datapath;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  minialu_mul_datapath_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .MUL_WIDTH(4)) bus ();

  minialu_mul_datapath #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (8),
    .MUL_WIDTH  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge and let outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ram_write(input logic [7:0] addr, input logic [15:0] data);
    bus.write_enable  = 1'b1;
    bus.write_address = addr;
    bus.data_in       = data;
    tick();
    bus.write_enable  = 1'b0;
  endtask

  initial begin
    logic [15:0] word;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.write_enable  = 1'b0;
    bus.write_address = '0;
    bus.data_in       = '0;
    bus.read_address0 = '0;
    bus.read_address1 = '0;
    bus.mul_enable    = 1'b0;

    #3;
    check("reset_product", {8'h00, bus.product}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // 15 x 15 through the RAM
    ram_write(8'd3, 16'h000F);
    ram_write(8'd5, 16'h000F);
    bus.read_address0 = 8'd3;
    bus.read_address1 = 8'd5;
    bus.mul_enable    = 1'b1;
    #1;
    check("read0_f", bus.data_out0, 16'h000F);
    check("read1_f", bus.data_out1, 16'h000F);
    check("comb_e1", {8'h00, bus.mul_comb}, 16'h00E1);
    check("prod_before_edge", {8'h00, bus.product}, 16'h0000);
    tick();
    check("prod_e1", {8'h00, bus.product}, 16'h00E1);
    bus.mul_enable = 1'b0;

    // Asynchronous reset in the middle of a clock period
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", {8'h00, bus.product}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_hold", {8'h00, bus.product}, 16'h0000);

    // Upper operand bits ignored: 4 x 3
    ram_write(8'd10, 16'h12A3);
    ram_write(8'd11, 16'h0B04);
    bus.read_address0 = 8'd10;
    bus.read_address1 = 8'd11;
    #1;
    check("mask_0c", {8'h00, bus.mul_comb}, 16'h000C);

    // 7 x 6, loaded into the product register
    ram_write(8'd20, 16'h0007);
    ram_write(8'd21, 16'h0006);
    bus.read_address0 = 8'd20;
    bus.read_address1 = 8'd21;
    bus.mul_enable    = 1'b1;
    #1;
    check("comb_2a", {8'h00, bus.mul_comb}, 16'h002A);
    tick();
    check("prod_2a", {8'h00, bus.product}, 16'h002A);
    bus.mul_enable = 1'b0;

    // 0 x 15 and 2 x 3 operands, written while the register holds
    ram_write(8'd22, 16'h0000);
    ram_write(8'd23, 16'h000F);
    ram_write(8'd24, 16'h0002);
    ram_write(8'd25, 16'h0003);
    bus.read_address0 = 8'd22;
    bus.read_address1 = 8'd23;
    #1;
    check("comb_zero", {8'h00, bus.mul_comb}, 16'h0000);
    bus.read_address0 = 8'd24;
    bus.read_address1 = 8'd25;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_2a", {8'h00, bus.product}, 16'h002A);
      check("hold_comb_06", {8'h00, bus.mul_comb}, 16'h0006);
    end
    bus.mul_enable = 1'b1;
    tick();
    check("prod_06", {8'h00, bus.product}, 16'h0006);
    bus.mul_enable = 1'b0;

    // Read during write, with a multiply in the same cycle
    ram_write(8'd0, 16'hAAAA);
    ram_write(8'd255, 16'h1111);
    bus.read_address0 = 8'd255;
    bus.read_address1 = 8'd255;
    bus.write_enable  = 1'b1;
    bus.write_address = 8'd255;
    bus.data_in       = 16'h2222;
    bus.mul_enable    = 1'b1;
    #1;
    check("rdw_old0", bus.data_out0, 16'h1111);
    check("rdw_old1", bus.data_out1, 16'h1111);
    tick();
    bus.write_enable = 1'b0;
    bus.mul_enable   = 1'b0;
    #1;
    check("rdw_new0", bus.data_out0, 16'h2222);
    check("rdw_new1", bus.data_out1, 16'h2222);
    check("rdw_prod_old_ops", {8'h00, bus.product}, 16'h0001);
    check("rdw_comb_new_ops", {8'h00, bus.mul_comb}, 16'h0004);
    bus.read_address0 = 8'd0;
    #1;
    check("addr0_intact", bus.data_out0, 16'hAAAA);

    // Every nibble pair; upper bits of each word carry noise
    for (int a = 0; a < 16; a++) begin
      word = 16'($urandom_range(0, 16'hFFFF));
      ram_write(8'(8'h30 + a), {word[15:4], 4'(a)});
    end
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        bus.read_address0 = 8'(8'h30 + a);
        bus.read_address1 = 8'(8'h30 + b);
        #1;
        check("sweep", {8'h00, bus.mul_comb}, 16'(a * b));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/minialu_mul_datapath.md
Name: minialu_mul_datapath

Overview:
Execution-side datapath slice for the MiniAlu processor. It holds a 2^ADDR_WIDTH x DATA_WIDTH data RAM with one synchronous write port and two asynchronous read ports. It multiplies the low MUL_WIDTH bits of both read operands with an unsigned shift-add array multiplier. The product is captured in an enabled output register. It sits between instruction decode (which supplies addresses and enables) and the ALU result mux / LED register.

Parameters:
DATA_WIDTH, 16, width of each RAM word and of the read/write data ports
ADDR_WIDTH, 8, RAM address width; depth = 2^ADDR_WIDTH (256)
MUL_WIDTH, 4, operand width of the array multiplier; product width = 2*MUL_WIDTH

Ports:
Clock  in  1  single system clock; all state updates on rising edge
Reset_n  in  1  asynchronous, active-low reset
iWriteEnable  in  1  RAM write strobe
iWriteAddress  in  ADDR_WIDTH  RAM write address
iDataIn  in  DATA_WIDTH  RAM write data
iReadAddress0  in  ADDR_WIDTH  read port 0 address
iReadAddress1  in  ADDR_WIDTH  read port 1 address
iMulEnable  in  1  load enable for product register
oDataOut0  out  DATA_WIDTH  read port 0 data (combinational)
oDataOut1  out  DATA_WIDTH  read port 1 data (combinational)
oMulComb  out  2*MUL_WIDTH  unregistered product of current operands
oProduct  out  2*MUL_WIDTH  registered product

Behaviour:
- RAM write: on rising Clock with iWriteEnable=1, mem[iWriteAddress] <= iDataIn. iWriteEnable=0: no change.
- RAM read: oDataOutN = mem[iReadAddressN], purely combinational, zero latency. Both ports are independent and may address the same word.
- Read during write to the same address: the read port shows the old word until the edge. It shows the new word immediately after the edge (write-before-next-read, no bypass).
- The RAM array is not affected by Reset_n. Contents are undefined until written, and software must write before reading. Addresses use the full ADDR_WIDTH range (0..255) with no wrap logic.
- Multiplier: oMulComb = unsigned(oDataOut1[MUL_WIDTH-1:0]) * unsigned(oDataOut0[MUL_WIDTH-1:0]).
  - Exact 2*MUL_WIDTH-bit result, no overflow possible.
  - Upper operand bits are ignored.
  - Built as MUL_WIDTH partial-product rows (AND of operand A with each bit of B, shifted left by bit index) summed by a ripple adder chain. Do not use the `*` operator.
- Product register: asynchronous clear to 0 when Reset_n=0. On rising Clock with Reset_n=1:
  - iMulEnable=1: oProduct <= oMulComb.
  - iMulEnable=0: oProduct holds.
- Latency: read address to oMulComb is combinational. Read address to oProduct is 1 clock (with iMulEnable=1).
- A RAM write and a multiply in the same cycle: the product uses the pre-write operands.
- Reset asserted mid-operation clears oProduct immediately (asynchronously), independent of Clock. Reset deassertion is synchronous-safe; the first load occurs at the first rising edge with Reset_n=1.
- No X propagation on oProduct after reset, even if the RAM is unwritten.

Decomposition:
- Shared package/defines: DATA_WIDTH/ADDR_WIDTH defaults, plus the operand-select constants RL/RH used by the enclosing ALU (not consumed here).
- Natural sub-modules:
  - dff_en_arst: parameterised width, enable, async active-low clear. Used for oProduct and reusable for opcode/address pipeline registers.
  - array_mul_unsigned: combinational, parameter MUL_WIDTH.
- The RAM stays inline.

Test Plan:
- Reset: Reset_n=0 mid-cycle with oProduct=0xE1 -> oProduct=0x00 before the next edge; it remains 0 for one edge after release while iMulEnable=0.
- Write/read: write 0x000F@3 and 0x000F@5. Read0=3, Read1=5, iMulEnable=1 -> oDataOut0=oDataOut1=0x000F, oMulComb=0xE1, oProduct=0xE1 one edge later.
- Operand masking: mem[10]=0x12A3, mem[11]=0x0B04 -> oMulComb=0x0C. Also 7x6 -> 0x2A, 0x0 x 0xF -> 0x00.
- Enable hold: product register loaded with 0x2A, operands changed to 2x3, iMulEnable=0 for 3 cycles -> oProduct stays 0x2A and oMulComb=0x06. Enable=1 -> oProduct=0x06.
- Read-during-write: mem[255]=0x1111. Write 0x2222@255 with both read ports at 255 -> both read 0x1111 before the edge and 0x2222 after. Address 0 written with 0xAAAA remains unaffected.
- Exhaustive multiplier: sweep all 256 nibble pairs via RAM -> oMulComb equals a*b for every pair.
